// File: rtl/lsu_ctrl_pkg.sv
// Shared widths, access-size encodings and FSM state type for the load/store controller.
package lsu_ctrl_pkg;

    localparam int XLEN             = 32;
    localparam int DTCM_ADDR_WIDTH  = 16;
    localparam int ITAG_WIDTH       = 1;
    localparam int WMASK_WIDTH      = XLEN / 8;
    localparam int DTCM_WADDR_WIDTH = DTCM_ADDR_WIDTH - 2;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Size 11 is illegal; halves need an even address, words a 4-byte aligned one.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = addr_lo[0];
            LSU_SIZE_W: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// AGU command/response, load write-back and DTCM SRAM signals of the load/store controller.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic                        agu_cmd_valid;
    logic                        agu_cmd_ready;
    logic [DTCM_ADDR_WIDTH-1:0]  agu_cmd_addr;
    logic                        agu_cmd_read;
    logic [ITAG_WIDTH-1:0]       agu_cmd_itag;
    logic [1:0]                  agu_cmd_size;
    logic                        agu_cmd_usign;
    logic [XLEN-1:0]             agu_cmd_wdata;
    logic [WMASK_WIDTH-1:0]      agu_cmd_wmask;

    logic                        agu_rsp_valid;
    logic                        agu_rsp_ready;
    logic [XLEN-1:0]             agu_rsp_rdata;
    logic                        agu_rsp_err;

    logic                        lsu_wbck_o_valid;
    logic                        lsu_wbck_o_ready;
    logic [XLEN-1:0]             lsu_wbck_o_data;
    logic [ITAG_WIDTH-1:0]       lsu_wbck_o_itag;
    logic                        lsu_wbck_o_err;

    logic                        dtcm_cs;
    logic                        dtcm_we;
    logic [DTCM_WADDR_WIDTH-1:0] dtcm_addr;
    logic [XLEN-1:0]             dtcm_wdata;
    logic [WMASK_WIDTH-1:0]      dtcm_wem;
    logic [XLEN-1:0]             dtcm_rdata;

    modport slave (
        input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_itag,
               agu_cmd_size, agu_cmd_usign, agu_cmd_wdata, agu_cmd_wmask,
        output agu_cmd_ready,
        output agu_rsp_valid, agu_rsp_rdata, agu_rsp_err,
        input  agu_rsp_ready,
        output lsu_wbck_o_valid, lsu_wbck_o_data, lsu_wbck_o_itag, lsu_wbck_o_err,
        input  lsu_wbck_o_ready,
        output dtcm_cs, dtcm_we, dtcm_addr, dtcm_wdata, dtcm_wem,
        input  dtcm_rdata
    );

    modport master (
        output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_itag,
               agu_cmd_size, agu_cmd_usign, agu_cmd_wdata, agu_cmd_wmask,
        input  agu_cmd_ready,
        input  agu_rsp_valid, agu_rsp_rdata, agu_rsp_err,
        output agu_rsp_ready,
        input  lsu_wbck_o_valid, lsu_wbck_o_data, lsu_wbck_o_itag, lsu_wbck_o_err,
        output lsu_wbck_o_ready,
        input  dtcm_cs, dtcm_we, dtcm_addr, dtcm_wdata, dtcm_wem,
        output dtcm_rdata
    );

endinterface

// File: rtl/lsu_ctrl_ld_align.sv
// Combinational load formatter: picks the byte/half lane out of the SRAM word and extends it.
module lsu_ld_align
    import lsu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            usign,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane [WMASK_WIDTH];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    generate
        for (genvar gi = 0; gi < WMASK_WIDTH; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lane[addr_lo];
        half_sel = addr_lo[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
        ext_bit  = 1'b0;
        data     = rdata;
        case (size)
            LSU_SIZE_B: begin
                ext_bit = ~usign & byte_sel[7];
                data    = {{(XLEN-8){ext_bit}}, byte_sel};
            end
            LSU_SIZE_H: begin
                ext_bit = ~usign & half_sel[15];
                data    = {{(XLEN-16){ext_bit}}, half_sel};
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between the AGU command port and the DTCM SRAM.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e            state_q, state_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [1:0]            size_q, size_d;
    logic                  usign_q, usign_d;
    logic [ITAG_WIDTH-1:0] itag_q, itag_d;
    logic                  read_q, read_d;
    logic                  err_q, err_d;
    logic [XLEN-1:0]       rsp_data_q, rsp_data_d;

    logic                  ld_rsp_valid;
    logic                  st_rsp_valid;
    logic                  rsp_hsk;
    logic                  cmd_ready;
    logic                  cmd_fire;
    logic                  cmd_err;
    logic                  sram_go;
    logic [XLEN-1:0]       ld_data;

    lsu_ld_align u_ld_align (
        .rdata   (bus.dtcm_rdata),
        .addr_lo (addr_lo_q),
        .size    (size_q),
        .usign   (usign_q),
        .data    (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        usign_d      = usign_q;
        itag_d       = itag_q;
        read_d       = read_q;
        err_d        = err_q;
        rsp_data_d   = rsp_data_q;

        ld_rsp_valid = (state_q == ST_RESP) & read_q;
        st_rsp_valid = (state_q == ST_RESP) & ~read_q;
        rsp_hsk      = (ld_rsp_valid & bus.lsu_wbck_o_ready) |
                       (st_rsp_valid & bus.agu_rsp_ready);
        cmd_ready    = (state_q == ST_IDLE) | rsp_hsk;
        cmd_fire     = bus.agu_cmd_valid & cmd_ready;
        cmd_err      = lsu_misaligned(bus.agu_cmd_size, bus.agu_cmd_addr[1:0]);
        // Reset gates the SRAM strobe so cs falls with rst rather than at the next edge.
        sram_go      = cmd_fire & ~cmd_err & ~rst;

        case (state_q)
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (read_q) begin
                    rsp_data_d = err_q ? '0 : ld_data;
                end
            end
            ST_RESP: begin
                if (rsp_hsk) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        if (cmd_fire) begin
            state_d   = ST_ACCESS;
            addr_lo_d = bus.agu_cmd_addr[1:0];
            size_d    = bus.agu_cmd_size;
            usign_d   = bus.agu_cmd_usign;
            itag_d    = bus.agu_cmd_itag;
            read_d    = bus.agu_cmd_read;
            err_d     = cmd_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_lo_q  <= '0;
            size_q     <= '0;
            usign_q    <= 1'b0;
            itag_q     <= '0;
            read_q     <= 1'b0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            usign_q    <= usign_d;
            itag_q     <= itag_d;
            read_q     <= read_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.agu_cmd_ready    = cmd_ready;

    assign bus.agu_rsp_valid    = st_rsp_valid;
    assign bus.agu_rsp_rdata    = '0;
    assign bus.agu_rsp_err      = st_rsp_valid & err_q;

    assign bus.lsu_wbck_o_valid = ld_rsp_valid;
    assign bus.lsu_wbck_o_data  = rsp_data_q;
    assign bus.lsu_wbck_o_itag  = itag_q;
    assign bus.lsu_wbck_o_err   = ld_rsp_valid & err_q;

    assign bus.dtcm_cs          = sram_go;
    assign bus.dtcm_we          = sram_go & ~bus.agu_cmd_read;
    assign bus.dtcm_addr        = sram_go ? bus.agu_cmd_addr[DTCM_ADDR_WIDTH-1:2] : '0;
    assign bus.dtcm_wdata       = sram_go ? bus.agu_cmd_wdata : '0;
    assign bus.dtcm_wem         = sram_go ? bus.agu_cmd_wmask : '0;

endmodule
